// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch stage placed directly after the program counter. Each
// cycle it may issue one read to a synchronous instruction memory (one cycle
// of read latency). Returned words are stored, tagged with their PC, in a
// small FIFO that feeds decode through a valid/ready handshake. full_o tells
// PC control to hold, and a taken branch (flush_i) empties the queue and
// cancels any read that is still in flight.
//
// Ports
//   clock_i        rising-edge clock
//   reset_n_i      asynchronous active-low reset
//   pc_i           address to fetch this cycle
//   pc_valid_i     pc_i is a real fetch request
//   flush_i        discard queued entries and the in-flight read
//   imem_rd_o      instruction-memory read strobe
//   imem_addr_o    instruction-memory address
//   imem_data_i    read data, valid the cycle after imem_rd_o
//   full_o         no slot for a new request; PC must hold
//   valid_o        instr_o / instr_pc_o hold a valid entry
//   ready_i        decode accepts the head entry
//   instr_o        head instruction
//   instr_pc_o     PC of the head instruction
//   instr_count_o  instructions delivered to decode since reset (saturating)
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clock_i,
   input  logic               reset_n_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic               pc_valid_i,
   input  logic               flush_i,
   output logic               imem_rd_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic               full_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   output logic [CNT_W-1:0]   instr_count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DepthVal = OCC_W'(DEPTH);

   // Entry storage (data path only, no reset needed)
   logic [INSTR_W-1:0] instrMem_q [DEPTH];
   logic [ADDR_W-1:0]  pcMem_q    [DEPTH];

   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [OCC_W-1:0]   used_q, used_d;
   logic               inFlight_q, inFlight_d;
   logic [ADDR_W-1:0]  inFlightPc_q, inFlightPc_d;
   logic [CNT_W-1:0]   instrCount_q, instrCount_d;
   logic [INSTR_W-1:0] headInstr_q, headInstr_d;
   logic [ADDR_W-1:0]  headPc_q, headPc_d;

   logic [OCC_W-1:0]   occupancy;
   logic               issueEn;
   logic               pushEn;
   logic               popEn;

   // Handshake and issue decisions. The in-flight read already owns a slot,
   // so full_o counts it; this keeps full_o a function of registered state
   // only and makes a push into a full queue impossible.
   always_comb begin
      occupancy   = used_q + OCC_W'(inFlight_q);
      full_o      = (occupancy == DepthVal);
      valid_o     = (used_q != '0);
      issueEn     = pc_valid_i & ~full_o & ~flush_i;
      pushEn      = inFlight_q & ~flush_i;
      popEn       = valid_o & ready_i;
      imem_rd_o   = issueEn;
      imem_addr_o = pc_i;
   end

   // Next-state for pointers, occupancy, in-flight tag, counter and head.
   // The head registers are refreshed from the entry that will sit at the
   // read pointer after this edge; when that entry is the one being written
   // right now it is taken straight from the memory return path. With an
   // empty result the head holds its previous value.
   always_comb begin
      wrPtr_d      = wrPtr_q;
      rdPtr_d      = rdPtr_q;
      used_d       = used_q;
      inFlight_d   = issueEn;
      inFlightPc_d = issueEn ? pc_i : inFlightPc_q;
      instrCount_d = instrCount_q;
      headInstr_d  = headInstr_q;
      headPc_d     = headPc_q;

      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         used_d  = '0;
      end else begin
         wrPtr_d = wrPtr_q + PTR_W'(pushEn);
         rdPtr_d = rdPtr_q + PTR_W'(popEn);
         used_d  = used_q + OCC_W'(pushEn) - OCC_W'(popEn);
      end

      if (popEn && (instrCount_q != '1)) begin
         instrCount_d = instrCount_q + CNT_W'(1);
      end

      if (!flush_i && (used_d != '0)) begin
         if (pushEn && (wrPtr_q == rdPtr_d)) begin
            headInstr_d = imem_data_i;
            headPc_d    = inFlightPc_q;
         end else begin
            headInstr_d = instrMem_q[rdPtr_d];
            headPc_d    = pcMem_q[rdPtr_d];
         end
      end
   end

   // Control and head registers; reset discards queue and in-flight read.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         used_q       <= '0;
         inFlight_q   <= 1'b0;
         inFlightPc_q <= '0;
         instrCount_q <= '0;
         headInstr_q  <= '0;
         headPc_q     <= '0;
      end else begin
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         used_q       <= used_d;
         inFlight_q   <= inFlight_d;
         inFlightPc_q <= inFlightPc_d;
         instrCount_q <= instrCount_d;
         headInstr_q  <= headInstr_d;
         headPc_q     <= headPc_d;
      end
   end

   // Returned word lands at the tail together with its PC tag.
   always_ff @(posedge clock_i) begin
      if (pushEn) begin
         instrMem_q[wrPtr_q] <= imem_data_i;
         pcMem_q[wrPtr_q]    <= inFlightPc_q;
      end
   end

   assign instr_o       = headInstr_q;
   assign instr_pc_o    = headPc_q;
   assign instr_count_o = instrCount_q;

endmodule
